// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, opcode and
// opext field values, the halt word and the decoded-instruction record.
// Optional feature macro: SEQ_HALT_EN (adds the HALT state).
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK
`ifdef SEQ_HALT_EN
        , ST_HALT
`endif
    } state_t;

    // Opcode field [15:12]
    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ANDI  = 4'h1;
    localparam logic [3:0] OP_ORI   = 4'h2;
    localparam logic [3:0] OP_XORI  = 4'h3;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_SUBI  = 4'h9;
    localparam logic [3:0] OP_CMPI  = 4'hB;
    localparam logic [3:0] OP_MOVI  = 4'hD;
    localparam logic [3:0] OP_LUI   = 4'hF;

    // Opext field [7:4] for R-type instructions
    localparam logic [3:0] EXT_AND = 4'h1;
    localparam logic [3:0] EXT_OR  = 4'h2;
    localparam logic [3:0] EXT_XOR = 4'h3;
    localparam logic [3:0] EXT_ADD = 4'h5;
    localparam logic [3:0] EXT_SUB = 4'h9;
    localparam logic [3:0] EXT_CMP = 4'hB;
    localparam logic [3:0] EXT_MOV = 4'hD;

    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    typedef struct packed {
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [3:0]  aluop;
        logic [3:0]  opext;
        logic        imm_sel;
        logic [15:0] imm;
        logic        is_write;
        logic        is_flag;
    } decode_t;

    // True for R-type opext values that the ALU implements.
    function automatic logic is_alu_ext(input logic [3:0] ext);
        return (ext == EXT_AND) || (ext == EXT_OR)  || (ext == EXT_XOR) ||
               (ext == EXT_ADD) || (ext == EXT_SUB) || (ext == EXT_CMP) ||
               (ext == EXT_MOV);
    endfunction

    // True for R-type opext values that update the PSR.
    function automatic logic is_flag_ext(input logic [3:0] ext);
        return (ext == EXT_ADD) || (ext == EXT_SUB) || (ext == EXT_CMP);
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch bus: request/address out of the sequencer,
// valid/data back from memory.
interface instr_sequencer_if;

    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );

endinterface

// File: rtl/instr_sequencer_decode.sv
// Purely combinational instruction decoder: IR -> register addresses, ALU
// control fields, extended immediate and write/flag classification.
module instr_decode
    import instr_sequencer_pkg::*;
(
    input  logic [15:0] ir,
    output decode_t     dec
);

    // Field extraction and immediate extension; unknown encodings decode as NOP.
    always_comb begin
        dec = '0;
        case (ir[15:12])
            OP_RTYPE: begin
                dec.aluop = OP_RTYPE;
                dec.opext = ir[7:4];
                dec.ra1   = ir[3:0];
                dec.ra2   = ir[11:8];
                if (is_alu_ext(ir[7:4])) begin
                    dec.is_write = (ir[7:4] != EXT_CMP);
                    dec.is_flag  = is_flag_ext(ir[7:4]);
                end
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_MOVI: begin
                dec.aluop    = ir[15:12];
                dec.ra2      = ir[11:8];
                dec.imm_sel  = 1'b1;
                dec.imm      = {8'h00, ir[7:0]};
                dec.is_write = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_CMPI: begin
                dec.aluop    = ir[15:12];
                dec.ra2      = ir[11:8];
                dec.imm_sel  = 1'b1;
                dec.imm      = {{8{ir[7]}}, ir[7:0]};
                dec.is_write = (ir[15:12] != OP_CMPI);
                dec.is_flag  = 1'b1;
            end
            OP_LUI: begin
                dec.aluop    = ir[15:12];
                dec.ra2      = ir[11:8];
                dec.imm_sel  = 1'b1;
                dec.imm      = {ir[7:0], 8'h00};
                dec.is_write = 1'b1;
            end
            default: begin
                dec = '0;
            end
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multicycle fetch/decode/execute/writeback sequencer for the 16-bit
// datapath. Holds the FSM, instruction register and program counter; field
// decoding lives in instr_decode.
// Optional feature macro: SEQ_HALT_EN (IR == 16'hFFFF enters a sticky HALT).
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                clk,
    input  logic                reset,
    instr_sequencer_if.master   imem,
    output logic [3:0]          ra1,
    output logic [3:0]          ra2,
    output logic [3:0]          wa,
    output logic                regwrite,
    output logic [3:0]          aluop,
    output logic [3:0]          opext,
    output logic                imm_sel,
    output logic [15:0]         imm,
    output logic                psr_we,
    output logic                halted
);

    state_t      state;
    logic [15:0] ir;
    logic [15:0] pc;
    logic        req_q;
    logic        psr_we_q;
    logic        regwrite_q;
    decode_t     dec;
`ifdef SEQ_HALT_EN
    logic        halted_q;
`endif

    instr_decode u_decode (
        .ir  (ir),
        .dec (dec)
    );

    // Sequencing FSM with registered request and write strobes; reset clears
    // the strobes immediately so no partial writeback can happen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ir         <= '0;
            pc         <= RESET_PC;
            req_q      <= 1'b0;
            psr_we_q   <= 1'b0;
            regwrite_q <= 1'b0;
`ifdef SEQ_HALT_EN
            halted_q   <= 1'b0;
`endif
        end else begin
            psr_we_q   <= 1'b0;
            regwrite_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state <= ST_FETCH;
                    req_q <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem.imem_valid) begin
                        ir    <= imem.imem_rdata;
                        pc    <= pc + 16'd1;
                        req_q <= 1'b0;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
`ifdef SEQ_HALT_EN
                    if (ir == HALT_WORD) begin
                        state    <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state    <= ST_EXECUTE;
                        psr_we_q <= dec.is_flag;
                    end
`else
                    state    <= ST_EXECUTE;
                    psr_we_q <= dec.is_flag;
`endif
                end
                ST_EXECUTE: begin
                    state      <= ST_WRITEBACK;
                    regwrite_q <= dec.is_write;
                end
                ST_WRITEBACK: begin
                    state <= ST_FETCH;
                    req_q <= 1'b1;
                end
`ifdef SEQ_HALT_EN
                ST_HALT: begin
                    state <= ST_HALT;
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;

    assign ra1      = dec.ra1;
    assign ra2      = dec.ra2;
    assign wa       = dec.ra2;
    assign aluop    = dec.aluop;
    assign opext    = dec.opext;
    assign imm_sel  = dec.imm_sel;
    assign imm      = dec.imm;
    assign psr_we   = psr_we_q;
    assign regwrite = regwrite_q;
`ifdef SEQ_HALT_EN
    assign halted   = halted_q;
`else
    assign halted   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed instructions from the
// bring-up list followed by randomized instruction words and memory wait
// states, checked cycle by cycle against a field-level reference decoder.
module tb_instr_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #10 clk = ~clk;

    instr_sequencer_if imem_bus ();
    instr_sequencer_if wrap_bus ();

    logic [3:0]  ra1, ra2, wa, aluop, opext;
    logic        regwrite, imm_sel, psr_we, halted;
    logic [15:0] imm;

    logic [3:0]  w_ra1, w_ra2, w_wa, w_aluop, w_opext;
    logic        w_regwrite, w_imm_sel, w_psr_we, w_halted;
    logic [15:0] w_imm;

    instr_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk      (clk),
        .reset    (reset),
        .imem     (imem_bus),
        .ra1      (ra1),
        .ra2      (ra2),
        .wa       (wa),
        .regwrite (regwrite),
        .aluop    (aluop),
        .opext    (opext),
        .imm_sel  (imm_sel),
        .imm      (imm),
        .psr_we   (psr_we),
        .halted   (halted)
    );

    instr_sequencer #(.RESET_PC(16'hFFFF)) wrap_dut (
        .clk      (clk),
        .reset    (reset),
        .imem     (wrap_bus),
        .ra1      (w_ra1),
        .ra2      (w_ra2),
        .wa       (w_wa),
        .regwrite (w_regwrite),
        .aluop    (w_aluop),
        .opext    (w_opext),
        .imm_sel  (w_imm_sel),
        .imm      (w_imm),
        .psr_we   (w_psr_we),
        .halted   (w_halted)
    );

    assign wrap_bus.imem_valid = 1'b1;
    assign wrap_bus.imem_rdata = 16'h0352;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_pc;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference decoder written straight from the instruction-set rules.
    task automatic ref_decode(
        input  logic [15:0] w,
        output logic [3:0]  e_ra1,
        output logic [3:0]  e_ra2,
        output logic [3:0]  e_aluop,
        output logic [3:0]  e_opext,
        output logic        e_sel,
        output logic [15:0] e_imm,
        output logic        e_flag,
        output logic        e_write,
        output logic        e_known
    );
        logic [3:0] op;
        logic [3:0] ext;
        int         v;
        op  = w[15:12];
        ext = w[7:4];
        v   = int'(w[7:0]);
        e_ra1 = 4'h0; e_ra2 = 4'h0; e_aluop = 4'h0; e_opext = 4'h0;
        e_sel = 1'b0; e_imm = 16'h0000; e_flag = 1'b0; e_write = 1'b0; e_known = 1'b0;
        if (op == 4'd0) begin
            e_known = 1'b1;
            e_opext = ext;
            e_ra1   = w[3:0];
            e_ra2   = w[11:8];
            e_flag  = (ext == 4'd5) || (ext == 4'd9) || (ext == 4'd11);
            e_write = (ext inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd9, 4'd13});
        end else if (op inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd9, 4'd11, 4'd13, 4'd15}) begin
            e_known = 1'b1;
            e_aluop = op;
            e_ra2   = w[11:8];
            e_sel   = 1'b1;
            e_flag  = (op == 4'd5) || (op == 4'd9) || (op == 4'd11);
            e_write = (op != 4'd11);
            if (op == 4'd15)
                v = v * 256;
            else if (e_flag && v > 127)
                v = v - 256;
            e_imm = 16'(v);
        end
    endtask

    task automatic check_fields(input string tag, input logic [15:0] word);
        logic [3:0]  e_ra1, e_ra2, e_aluop, e_opext;
        logic        e_sel, e_flag, e_write, e_known;
        logic [15:0] e_imm;
        ref_decode(word, e_ra1, e_ra2, e_aluop, e_opext, e_sel, e_imm, e_flag, e_write, e_known);
        if (e_known) begin
            check({"ra1_", tag},     16'(ra1),     16'(e_ra1));
            check({"ra2_", tag},     16'(ra2),     16'(e_ra2));
            check({"wa_", tag},      16'(wa),      16'(e_ra2));
            check({"aluop_", tag},   16'(aluop),   16'(e_aluop));
            check({"opext_", tag},   16'(opext),   16'(e_opext));
            check({"imm_sel_", tag}, 16'(imm_sel), 16'(e_sel));
            check({"imm_", tag},     imm,          e_imm);
        end
    endtask

    // Entered at a negedge in FETCH; returns at the negedge of the next FETCH.
    task automatic run_instr(input logic [15:0] word, input int unsigned waits);
        logic [3:0]  e_ra1, e_ra2, e_aluop, e_opext;
        logic        e_sel, e_flag, e_write, e_known;
        logic [15:0] e_imm;
        ref_decode(word, e_ra1, e_ra2, e_aluop, e_opext, e_sel, e_imm, e_flag, e_write, e_known);
        for (int unsigned i = 0; i < waits; i++) begin
            imem_bus.imem_valid = 1'b0;
            imem_bus.imem_rdata = 16'($urandom);
            check("req_wait",     16'(imem_bus.imem_req), 16'd1);
            check("addr_wait",    imem_bus.imem_addr,     exp_pc);
            check("strobes_wait", 16'({psr_we, regwrite}), 16'd0);
            @(negedge clk);
        end
        check("req_fetch",  16'(imem_bus.imem_req), 16'd1);
        check("addr_fetch", imem_bus.imem_addr,     exp_pc);
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_rdata = word;
        @(negedge clk);
        exp_pc = exp_pc + 16'd1;
        // valid outside FETCH must be ignored
        imem_bus.imem_valid = 1'($urandom % 2);
        imem_bus.imem_rdata = 16'($urandom);
        check("req_decode",     16'(imem_bus.imem_req), 16'd0);
        check("addr_decode",    imem_bus.imem_addr,     exp_pc);
        check("strobes_decode", 16'({psr_we, regwrite}), 16'd0);
        check_fields("decode", word);
        @(negedge clk);
        check("psr_we_exec",   16'(psr_we),   16'(e_flag));
        check("regwrite_exec", 16'(regwrite), 16'd0);
        check("req_exec",      16'(imem_bus.imem_req), 16'd0);
        check_fields("exec", word);
        @(negedge clk);
        check("regwrite_wb", 16'(regwrite), 16'(e_write));
        check("psr_we_wb",   16'(psr_we),   16'd0);
        check("req_wb",      16'(imem_bus.imem_req), 16'd0);
        check_fields("wb", word);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({"ra1_", tag},      16'(ra1),      16'd0);
        check({"ra2_", tag},      16'(ra2),      16'd0);
        check({"wa_", tag},       16'(wa),       16'd0);
        check({"aluop_", tag},    16'(aluop),    16'd0);
        check({"opext_", tag},    16'(opext),    16'd0);
        check({"imm_sel_", tag},  16'(imm_sel),  16'd0);
        check({"imm_", tag},      imm,           16'd0);
        check({"psr_we_", tag},   16'(psr_we),   16'd0);
        check({"regwrite_", tag}, 16'(regwrite), 16'd0);
        check({"halted_", tag},   16'(halted),   16'd0);
        check({"req_", tag},      16'(imem_bus.imem_req), 16'd0);
        check({"addr_", tag},     imem_bus.imem_addr,     16'h0000);
    endtask

    // Holds reset two cycles, releases, checks the IDLE cycle; returns in FETCH.
    task automatic do_reset();
        reset = 1'b1;
        imem_bus.imem_valid = 1'b0;
        imem_bus.imem_rdata = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        check("wrap_addr_reset", wrap_bus.imem_addr, 16'hFFFF);
        reset = 1'b0;
        #1;
        check("req_idle", 16'(imem_bus.imem_req), 16'd0);
        @(negedge clk);
        exp_pc = 16'h0000;
    endtask

    task automatic reset_in_exec();
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_rdata = 16'h0352;
        @(negedge clk);
        imem_bus.imem_valid = 1'b0;
        @(negedge clk);
        check("psr_we_before_kill", 16'(psr_we), 16'd1);
        #2 reset = 1'b1;
        #1 check_all_zero("kill");
        @(negedge clk);
        check("regwrite_during_kill", 16'(regwrite), 16'd0);
        reset = 1'b0;
        #1;
        check("req_after_kill", 16'(imem_bus.imem_req), 16'd0);
        check("regwrite_after_kill", 16'(regwrite), 16'd0);
        @(negedge clk);
        check("req_refetch",  16'(imem_bus.imem_req), 16'd1);
        check("addr_refetch", imem_bus.imem_addr,     16'h0000);
        exp_pc = 16'h0000;
    endtask

`ifdef SEQ_HALT_EN
    task automatic run_halt();
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_rdata = 16'hFFFF;
        @(negedge clk);
        imem_bus.imem_valid = 1'b0;
        check("halted_decode", 16'(halted), 16'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halted_hold",  16'(halted), 16'd1);
            check("req_halt",     16'(imem_bus.imem_req), 16'd0);
            check("strobes_halt", 16'({psr_we, regwrite}), 16'd0);
        end
        do_reset();
        check("halted_cleared", 16'(halted), 16'd0);
    endtask
`endif

    initial begin
        logic [15:0] word;
        logic [3:0]  op;
        do_reset();

        // ADD R3,R2 with zero-wait memory; wrap instance fetches in lockstep
        check("req_first",  16'(imem_bus.imem_req), 16'd1);
        run_instr(16'h0352, 0);
        check("wrap_addr_after_one", wrap_bus.imem_addr, 16'h0000);
        check("addr_second", imem_bus.imem_addr, 16'h0001);

        run_instr(16'hB1FF, 0);  // CMPI R1,#-1
        run_instr(16'h1280, 1);  // ANDI
        run_instr(16'hF4AB, 2);  // LUI
`ifndef SEQ_HALT_EN
        run_instr(16'hFFFF, 0);  // LUI R15,#0xFF
`endif
        run_instr(16'h0295, 5);  // SUB after 5 wait cycles
        run_instr(16'h0000, 0);  // IR=0 is a NOP
        run_instr(16'h7123, 1);  // unknown opcode
        run_instr(16'h0A7C, 0);  // unknown opext

        for (int n = 0; n < 80; n++) begin
            op = 4'($urandom);
            if ($urandom % 3 == 0)
                op = 4'h0;
            word = {op, 12'($urandom)};
`ifdef SEQ_HALT_EN
            if (word == 16'hFFFF)
                word = 16'hFFFE;
`endif
            run_instr(word, ($urandom % 5 == 0) ? 5 : $urandom % 3);
        end

        reset_in_exec();
        run_instr(16'h5A80, 0);  // ADDI after recovery, fetched from RESET_PC

`ifdef SEQ_HALT_EN
        run_halt();
        run_instr(16'h0352, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
